sync_timing_receiver: RTL and testbench

SYNC_TIMING_RECEIVER -- requirements
Module: sync_timing_receiver

---
 rtl/sync_timing_receiver_pkg.sv | 25 ++
 rtl/sync_timing_receiver_edge.sv | 33 +++
 rtl/sync_timing_receiver.sv | 201 ++++++++++++++++++++
 tb/tb_sync_timing_receiver.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sync_timing_receiver_pkg.sv
// Shared types and constants for the sync timing receiver.
package sync_timing_receiver_pkg;

    localparam int H_WIDTH  = 11;
    localparam int V_WIDTH  = 10;
    localparam int MC_WIDTH = 3;

    localparam logic [H_WIDTH-1:0] H_SAT = '1;
    localparam logic [V_WIDTH-1:0] V_SAT = '1;

    typedef enum logic [1:0] {
        SEARCH,
        ACQUIRE,
        LOCKED
    } state_t;

    function automatic logic [H_WIDTH-1:0] h_inc(input logic [H_WIDTH-1:0] v);
        return (v == H_SAT) ? v : v + 1'b1;
    endfunction

    function automatic logic [V_WIDTH-1:0] v_inc(input logic [V_WIDTH-1:0] v);
        return (v == V_SAT) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_timing_receiver_edge.sv
// Two-stage sync sampler with leading-edge pulse; active_o is aligned with edge_o.
module sync_edge_detector #(
    parameter bit ACTIVE_HIGH = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sync_i,
    output logic active_o,
    output logic edge_o
);

    localparam logic INACTIVE = ~ACTIVE_HIGH;

    logic s1_q;
    logic s2_q;
    logic edge_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q   <= INACTIVE;
            s2_q   <= INACTIVE;
            edge_q <= 1'b0;
        end else begin
            s1_q   <= sync_i;
            s2_q   <= s1_q;
            edge_q <= (s1_q == ACTIVE_HIGH) && (s2_q != ACTIVE_HIGH);
        end
    end

    assign active_o = (s2_q == ACTIVE_HIGH);
    assign edge_o   = edge_q;

endmodule

// File: rtl/sync_timing_receiver.sv
// Measures line/frame geometry from hsync/vsync and declares lock once
// LOCK_FRAMES consecutive complete frames repeat the same geometry.
module sync_timing_receiver
    import sync_timing_receiver_pkg::*;
#(
    parameter bit HSYNC_POLARITY_IS_POSITIVE = 1'b0,
    parameter bit VSYNC_POLARITY_IS_POSITIVE = 1'b0,
    parameter int LOCK_FRAMES                = 2
) (
    input  logic               clkPixel,
    input  logic               reset,
    input  logic               hsyncIn,
    input  logic               vsyncIn,
    output logic               lineStart,
    output logic               frameStart,
    output logic [H_WIDTH-1:0] hPos,
    output logic [V_WIDTH-1:0] vPos,
    output logic [H_WIDTH-1:0] hTotal,
    output logic [H_WIDTH-1:0] hSyncWidth,
    output logic [V_WIDTH-1:0] vTotal,
    output logic [V_WIDTH-1:0] vSyncWidth,
    output logic               locked,
    output logic               timeout
);

    localparam logic [MC_WIDTH-1:0] LOCK_MC = MC_WIDTH'(LOCK_FRAMES);

    logic lsEv, fsEv, hAct, vAct;

    sync_edge_detector #(.ACTIVE_HIGH(HSYNC_POLARITY_IS_POSITIVE)) u_hsync (
        .clk_i(clkPixel), .rst_i(reset), .sync_i(hsyncIn), .active_o(hAct), .edge_o(lsEv)
    );

    sync_edge_detector #(.ACTIVE_HIGH(VSYNC_POLARITY_IS_POSITIVE)) u_vsync (
        .clk_i(clkPixel), .rst_i(reset), .sync_i(vsyncIn), .active_o(vAct), .edge_o(fsEv)
    );

    state_t               state_q, state_d;
    logic [H_WIDTH-1:0]   hPos_q, hPos_d, hTotal_q, hTotal_d, hSyncWidth_q, hSyncWidth_d;
    logic [H_WIDTH-1:0]   hActCnt_q, hActCnt_d, refHTotal_q, refHTotal_d, hTotalNew;
    logic [V_WIDTH-1:0]   vPos_q, vPos_d, vTotal_q, vTotal_d, vSyncWidth_q, vSyncWidth_d;
    logic [V_WIDTH-1:0]   vActCnt_q, vActCnt_d, vTotalNew;
    logic [H_WIDTH-1:0]   prevHTotal_q, prevHTotal_d, prevHSync_q, prevHSync_d;
    logic [V_WIDTH-1:0]   prevVTotal_q, prevVTotal_d, prevVSync_q, prevVSync_d;
    logic [MC_WIDTH-1:0]  matchCount_q, matchCount_d;
    logic                 lineStart_q, frameStart_q, timeout_q, timeout_d;
    logic                 refValid_q, refValid_d, inconsistent_q, inconsistent_d;
    logic                 havePrev_q, havePrev_d;
    logic                 vLineAct, lineMismatch, inconsistentNow, frameMatch;

    always_comb begin
        hTotalNew    = h_inc(hPos_q);
        vTotalNew    = v_inc(vPos_q);
        hPos_d       = lsEv ? '0 : h_inc(hPos_q);
        vPos_d       = vPos_q;
        if (fsEv)      vPos_d = '0;
        else if (lsEv) vPos_d = v_inc(vPos_q);

        hTotal_d     = hTotal_q;
        hSyncWidth_d = hSyncWidth_q;
        hActCnt_d    = hAct ? h_inc(hActCnt_q) : hActCnt_q;
        if (lsEv) begin
            hTotal_d     = hTotalNew;
            hSyncWidth_d = hActCnt_q;
            hActCnt_d    = H_WIDTH'(hAct);
        end

        // vsync width is measured in lineStarts seen while vsync is active
        vLineAct     = lsEv && vAct;
        vTotal_d     = vTotal_q;
        vSyncWidth_d = vSyncWidth_q;
        vActCnt_d    = vLineAct ? v_inc(vActCnt_q) : vActCnt_q;
        if (fsEv) begin
            vTotal_d     = vTotalNew;
            vSyncWidth_d = vActCnt_q;
            vActCnt_d    = V_WIDTH'(vLineAct);
        end

        timeout_d = ((hPos_d == H_SAT) && (hPos_q != H_SAT)) ||
                    ((vPos_d == V_SAT) && (vPos_q != V_SAT));
    end

    // A lineStart coinciding with the closing frameStart ends the closed frame's last line.
    always_comb begin
        lineMismatch    = lsEv && refValid_q && (hTotalNew != refHTotal_q);
        inconsistentNow = inconsistent_q || lineMismatch;
        refHTotal_d     = refHTotal_q;
        refValid_d      = refValid_q;
        inconsistent_d  = inconsistentNow;
        if (fsEv) begin
            refValid_d     = 1'b0;
            inconsistent_d = 1'b0;
        end else if (lsEv && !refValid_q) begin
            refHTotal_d = hTotalNew;
            refValid_d  = 1'b1;
        end

        frameMatch = havePrev_q && !inconsistentNow &&
                     (hTotal_d == prevHTotal_q) && (hSyncWidth_d == prevHSync_q) &&
                     (vTotal_d == prevVTotal_q) && (vSyncWidth_d == prevVSync_q);

        prevHTotal_d = prevHTotal_q;
        prevHSync_d  = prevHSync_q;
        prevVTotal_d = prevVTotal_q;
        prevVSync_d  = prevVSync_q;
        havePrev_d   = havePrev_q;
        matchCount_d = matchCount_q;
        if (fsEv) begin
            if (state_q == SEARCH) begin
                havePrev_d   = 1'b0;
                matchCount_d = '0;
            end else begin
                prevHTotal_d = hTotal_d;
                prevHSync_d  = hSyncWidth_d;
                prevVTotal_d = vTotal_d;
                prevVSync_d  = vSyncWidth_d;
                havePrev_d   = 1'b1;
                if (!frameMatch)              matchCount_d = '0;
                else if (matchCount_q != '1)  matchCount_d = matchCount_q + 1'b1;
            end
        end
        if (timeout_d) begin
            havePrev_d   = 1'b0;
            matchCount_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout_d) begin
            state_d = SEARCH;
        end else begin
            unique case (state_q)
                SEARCH:  if (fsEv) state_d = ACQUIRE;
                ACQUIRE: if (matchCount_q >= LOCK_MC) state_d = LOCKED;
                LOCKED:  if (matchCount_q == '0) state_d = ACQUIRE;
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clkPixel) begin
        if (reset) begin
            state_q        <= SEARCH;
            hPos_q         <= '0;
            vPos_q         <= '0;
            hTotal_q       <= '0;
            hSyncWidth_q   <= '0;
            vTotal_q       <= '0;
            vSyncWidth_q   <= '0;
            hActCnt_q      <= '0;
            vActCnt_q      <= '0;
            refHTotal_q    <= '0;
            refValid_q     <= 1'b0;
            inconsistent_q <= 1'b0;
            prevHTotal_q   <= '0;
            prevHSync_q    <= '0;
            prevVTotal_q   <= '0;
            prevVSync_q    <= '0;
            havePrev_q     <= 1'b0;
            matchCount_q   <= '0;
            lineStart_q    <= 1'b0;
            frameStart_q   <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            hPos_q         <= hPos_d;
            vPos_q         <= vPos_d;
            hTotal_q       <= hTotal_d;
            hSyncWidth_q   <= hSyncWidth_d;
            vTotal_q       <= vTotal_d;
            vSyncWidth_q   <= vSyncWidth_d;
            hActCnt_q      <= hActCnt_d;
            vActCnt_q      <= vActCnt_d;
            refHTotal_q    <= refHTotal_d;
            refValid_q     <= refValid_d;
            inconsistent_q <= inconsistent_d;
            prevHTotal_q   <= prevHTotal_d;
            prevHSync_q    <= prevHSync_d;
            prevVTotal_q   <= prevVTotal_d;
            prevVSync_q    <= prevVSync_d;
            havePrev_q     <= havePrev_d;
            matchCount_q   <= matchCount_d;
            lineStart_q    <= lsEv;
            frameStart_q   <= fsEv;
            timeout_q      <= timeout_d;
        end
    end

    assign lineStart  = lineStart_q;
    assign frameStart = frameStart_q;
    assign hPos       = hPos_q;
    assign vPos       = vPos_q;
    assign hTotal     = hTotal_q;
    assign hSyncWidth = hSyncWidth_q;
    assign vTotal     = vTotal_q;
    assign vSyncWidth = vSyncWidth_q;
    assign locked     = (state_q == LOCKED);
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_sync_timing_receiver.sv
// Bench for sync_timing_receiver: an active-low and an active-high instance share one stimulus.
module tb_sync_timing_receiver;

    logic clkPixel = 1'b0;
    logic reset;
    logic hsA, vsA;
    logic hsN, vsN;
    assign hsN = ~hsA;
    assign vsN = ~vsA;

    logic        ls, fs, lk, to, lsP, fsP, lkP, toP;
    logic [10:0] hPos, hTot, hSw, hPosP, hTotP, hSwP;
    logic [9:0]  vPos, vTot, vSw, vPosP, vTotP, vSwP;

    sync_timing_receiver dut (
        .clkPixel(clkPixel), .reset(reset), .hsyncIn(hsN), .vsyncIn(vsN),
        .lineStart(ls), .frameStart(fs), .hPos(hPos), .vPos(vPos),
        .hTotal(hTot), .hSyncWidth(hSw), .vTotal(vTot), .vSyncWidth(vSw),
        .locked(lk), .timeout(to)
    );

    sync_timing_receiver #(
        .HSYNC_POLARITY_IS_POSITIVE(1'b1), .VSYNC_POLARITY_IS_POSITIVE(1'b1), .LOCK_FRAMES(2)
    ) dutp (
        .clkPixel(clkPixel), .reset(reset), .hsyncIn(hsA), .vsyncIn(vsA),
        .lineStart(lsP), .frameStart(fsP), .hPos(hPosP), .vPos(vPosP),
        .hTotal(hTotP), .hSyncWidth(hSwP), .vTotal(vTotP), .vSyncWidth(vSwP),
        .locked(lkP), .timeout(toP)
    );

    always #5 clkPixel = ~clkPixel;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lastFs = 0;
    int fallGap = -1;
    int toCount = 0;
    logic lkPrev = 1'b0;

    typedef struct {
        int hT, hW, vT, vW;
        int expHT, expHW, expVT, expVW;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_hPos"}, hPos, 0);
        chk({tag, "_vPos"}, vPos, 0);
        chk({tag, "_hTotal"}, hTot, 0);
        chk({tag, "_hSyncWidth"}, hSw, 0);
        chk({tag, "_vTotal"}, vTot, 0);
        chk({tag, "_vSyncWidth"}, vSw, 0);
        chk({tag, "_pulses"}, {ls, fs, lk, to}, 0);
    endtask

    task automatic do_reset();
        @(negedge clkPixel);
        reset = 1'b1; hsA = 1'b0; vsA = 1'b0;
        repeat (2) @(negedge clkPixel);
        reset = 1'b0;
    endtask

    // One frame: every line starts with hsync, the first vW lines carry vsync.
    task automatic drive_frame(input int hT, input int hW, input int vT, input int vW,
                               input int skip, input int longLine, input int extra);
        int len;
        for (int l = 0; l < vT; l++) begin
            len = hT + ((l == longLine) ? extra : 0);
            for (int c = 0; c < len; c++) begin
                if (!(l == 0 && c < skip)) begin
                    @(negedge clkPixel);
                    hsA = (c < hW);
                    vsA = (l < vW);
                end
            end
        end
    endtask

    // Start of the next frame, long enough for the closing frameStart to settle the lock state.
    task automatic tail(input int hW);
        for (int c = 0; c < 5; c++) begin
            @(negedge clkPixel);
            hsA = (c < hW);
            vsA = 1'b1;
        end
        #1;
    endtask

    task automatic lock_run(input vec_t v, input string tag);
        for (int f = 0; f < 3; f++) drive_frame(v.hT, v.hW, v.vT, v.vW, 0, -1, 0);
        #1;
        chk({tag, "_locked_after3"}, lk, 0);
        tail(v.hW);
        chk({tag, "_hTotal"}, hTot, v.expHT);
        chk({tag, "_hSyncWidth"}, hSw, v.expHW);
        chk({tag, "_vTotal"}, vTot, v.expVT);
        chk({tag, "_vSyncWidth"}, vSw, v.expVW);
        chk({tag, "_locked"}, lk, 1);
        chk({tag, "_hPos"}, hPos, 1);
        chk({tag, "_vPos"}, vPos, 0);
        chk({tag, "_pos_meas"}, {hTotP, hSwP, vTotP, vSwP},
            {11'(v.expHT), 11'(v.expHW), 10'(v.expVT), 10'(v.expVW)});
        chk({tag, "_pos_locked"}, lkP, 1);
    endtask

    // Stream-level observer: pulse alignment and lock-drop timing.
    initial forever begin
        @(negedge clkPixel);
        cyc++;
        if (to) toCount++;
        if (fs) begin
            lastFs = cyc;
            chk("fs_with_ls_vpos0", {ls, (vPos == 10'd0)}, 2'b11);
        end
        if (ls) chk("ls_hpos0", hPos, 0);
        if (lkPrev && !lk) fallGap = cyc - lastFs;
        lkPrev = lk;
    end

    vec_t tbl[6];
    int t0, h, w, vt, vw;

    initial begin
        reset = 1'b1; hsA = 1'b0; vsA = 1'b0;
        repeat (2) @(negedge clkPixel);
        #1;
        chk_zero("reset");
        @(negedge clkPixel);
        reset = 1'b0;

        // Pulse latency: input sampled active at E0, pulse visible after E2.
        repeat (3) @(negedge clkPixel);
        hsA = 1'b1; vsA = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clkPixel);
            #1;
            chk($sformatf("latency_ls_%0d", k), ls, (k == 3) ? 1 : 0);
            chk($sformatf("latency_fs_%0d", k), fs, (k == 3) ? 1 : 0);
        end
        hsA = 1'b0; vsA = 1'b0;

        // vPos saturation on a stream of short lines with no vsync.
        do_reset();
        t0 = toCount;
        drive_frame(4, 1, 1030, 0, 0, -1, 0);
        #1;
        chk("vsat_vPos", vPos, 1023);
        chk("vsat_timeouts", toCount - t0, 1);
        chk("vsat_hTotal", hTot, 4);
        chk("vsat_hSyncWidth", hSw, 1);

        tbl[0] = '{400, 48, 12, 2, 400, 48, 12, 2};
        tbl[1] = '{64, 8, 10, 3, 64, 8, 10, 3};
        tbl[2] = '{32, 31, 6, 5, 32, 31, 6, 5};
        for (int i = 3; i < 6; i++) begin
            h  = $urandom_range(60, 16);
            w  = $urandom_range(h - 2, 1);
            vt = $urandom_range(10, 4);
            vw = $urandom_range(vt - 1, 1);
            tbl[i] = '{h, w, vt, vw, h, w, vt, vw};
        end
        for (int i = 0; i < 6; i++) begin
            do_reset();
            lock_run(tbl[i], $sformatf("vec%0d", i));
        end

        // One long line breaks lock; two clean frames restore it.
        do_reset();
        lock_run('{40, 5, 8, 2, 40, 5, 8, 2}, "pre_long");
        drive_frame(40, 5, 8, 2, 5, 3, 1);
        tail(5);
        chk("long_locked", lk, 0);
        chk("long_fall_gap", fallGap, 1);
        drive_frame(40, 5, 8, 2, 5, -1, 0);
        tail(5);
        chk("relock1_locked", lk, 0);
        drive_frame(40, 5, 8, 2, 5, -1, 0);
        tail(5);
        chk("relock2_locked", lk, 1);

        // Single-cycle reset mid-frame while locked.
        drive_frame(40, 5, 5, 2, 5, -1, 0);
        #1;
        chk("mid_vPos", vPos, 4);
        chk("mid_locked", lk, 1);
        @(negedge clkPixel);
        reset = 1'b1;
        @(negedge clkPixel);
        reset = 1'b0;
        #1;
        chk_zero("midreset");
        lock_run('{40, 5, 8, 2, 40, 5, 8, 2}, "after_reset");

        // hsync lost: hPos saturates, one timeout, back to search.
        t0 = toCount;
        hsA = 1'b0; vsA = 1'b0;
        repeat (2100) @(negedge clkPixel);
        #1;
        chk("hsat_timeouts", toCount - t0, 1);
        chk("hsat_hPos", hPos, 2047);
        chk("hsat_locked", lk, 0);
        lock_run('{40, 5, 8, 2, 40, 5, 8, 2}, "after_timeout");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
